// File: rtl/sng_pkg.sv
// sng_array shared types: FSM state, trailing-zero helper, LFSR tap masks.
// Optional LFSR selection mode is enabled by the SNG_LFSR_EN macro.
package sng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } sng_state_e;

  // Maximal-length feedback masks, bit i = tap i+1, indexed by WIDTH.
  localparam logic [7:0] SNG_LFSR_TAPS [3:8] = '{
    8'h06, 8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8
  };

  function automatic int sng_tz(input logic [8:0] v);
    int n;
    logic found;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sng_if.sv
// sng_array operand/handshake bundle.
// master drives operands and requests; slave returns the streams.
interface sng_if #(
  parameter int WIDTH = 4,
  parameter int CH    = 4
);
  logic [CH*WIDTH-1:0] i_x_bn;
  logic                i_start_sng;
  logic                i_stop_sng;
  logic [CH-1:0]       o_sn_bits;
  logic                o_sn_valid;
  logic                o_sn_last;
  logic                o_done;
  logic                o_aborted;
  logic                o_busy;

  modport master (
    output i_x_bn, i_start_sng, i_stop_sng,
    input  o_sn_bits, o_sn_valid, o_sn_last,
    input  o_done, o_aborted, o_busy
  );

  modport slave (
    input  i_x_bn, i_start_sng, i_stop_sng,
    output o_sn_bits, o_sn_valid, o_sn_last,
    output o_done, o_aborted, o_busy
  );
endinterface

// File: rtl/sng_sel_gen.sv
// Shared bit-selection logic: trailing-zero select and LFSR next state.
// The LFSR step is only consumed when SNG_LFSR_EN is defined.
module sng_sel_gen
  import sng_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] k_i,
  input  logic [WIDTH-1:0] lfsr_i,
  output logic [SW-1:0]    sel_o,
  output logic             sel_valid_o,
  output logic [WIDTH-1:0] lfsr_o
);

  localparam logic [WIDTH-1:0] TAPS =
    SNG_LFSR_TAPS[WIDTH][WIDTH-1:0];

  logic [WIDTH:0] kp1;
  int             tz;

  // Select bit W-1-tz(k+1); the final stream slot has no valid bit.
  always_comb begin
    kp1         = {1'b0, k_i} + (WIDTH+1)'(1);
    tz          = sng_tz(9'(kp1));
    sel_valid_o = ~&k_i;
    sel_o       = '0;
    if (sel_valid_o) sel_o = SW'(WIDTH - 1 - tz);
  end

  // Fibonacci step: shift left, feed back parity of tapped bits.
  always_comb begin
    lfsr_o = {lfsr_i[WIDTH-2:0], ^(lfsr_i & TAPS)};
  end

endmodule

// File: rtl/sng_array.sv
// Multi-channel stochastic number generator with aligned streams.
// Define SNG_LFSR_EN for LFSR comparison instead of bit selection.
module sng_array
  import sng_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CH        = 4,
  parameter int LFSR_SEED = 1
) (
  input logic i_clk_sng,
  input logic i_rst_sng,
  sng_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  sng_state_e          state_q, state_d;
  logic [WIDTH-1:0]    k_q, k_d;
  logic [CH*WIDTH-1:0] x_q, x_d;
  logic                ab_q, ab_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_nxt;
  logic [SW-1:0]       sel;
  logic                sel_valid;
  logic                gen;
  logic                accept;
  logic [CH-1:0]       bits;

  assign gen    = (state_q == GEN);
  assign accept = (state_q == IDLE) && bus.i_start_sng;

  // State, counter, latched operands and abort flag.
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      ab_q    <= ab_d;
    end
  end

  // Next state; the last slot completes normally even if stop is set.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    ab_d    = ab_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start_sng) begin
          x_d     = bus.i_x_bn;
          k_d     = '0;
          ab_d    = 1'b0;
          state_d = GEN;
        end
      end
      GEN: begin
        k_d = k_q + 1'b1;
        if (&k_q) begin
          ab_d    = 1'b0;
          state_d = DONE;
        end else if (bus.i_stop_sng) begin
          ab_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sng_sel_gen #(.WIDTH(WIDTH)) u_sel (
    .k_i        (k_q),
    .lfsr_i     (lfsr_q),
    .sel_o      (sel),
    .sel_valid_o(sel_valid),
    .lfsr_o     (lfsr_nxt)
  );

`ifdef SNG_LFSR_EN
  logic unused_sel;
  assign unused_sel = ^sel;

  // Shared LFSR: reseeded on start, stepped once per stream cycle.
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) lfsr_q <= WIDTH'(LFSR_SEED);
    else if (accept) lfsr_q <= WIDTH'(LFSR_SEED);
    else if (gen) lfsr_q <= lfsr_nxt;
  end
`else
  localparam int unused_seed = LFSR_SEED;
  logic unused_lfsr;
  assign lfsr_q      = '0;
  assign unused_lfsr = ^{lfsr_nxt, accept};
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [WIDTH-1:0] xc;
    assign xc = x_q[c*WIDTH +: WIDTH];
`ifdef SNG_LFSR_EN
    assign bits[c] = gen & sel_valid & (lfsr_q <= xc);
`else
    assign bits[c] = gen & sel_valid & xc[sel];
`endif
  end

  assign bus.o_sn_bits  = bits;
  assign bus.o_sn_valid = gen;
  assign bus.o_sn_last  = gen && (&k_q);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_aborted  = (state_q == DONE) && ab_q;
  assign bus.o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sng_array.sv
// Randomized and directed bench for sng_array against a stream model.
// Build with SNG_LFSR_EN to exercise the LFSR variant (WIDTH=5, CH=2).
module tb_sng_array;

`ifdef SNG_LFSR_EN
  localparam int W  = 5;
  localparam int CH = 2;
`else
  localparam int W  = 4;
  localparam int CH = 4;
`endif
  localparam int L  = 1 << W;
  localparam int XW = CH * W;
  localparam int OW = 5 + CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [L-1:0] s0;

  always #5 clk = ~clk;

  sng_if #(.WIDTH(W), .CH(CH)) bus ();

  sng_array #(.WIDTH(W), .CH(CH), .LFSR_SEED(1)) dut (
    .i_clk_sng(clk),
    .i_rst_sng(rst),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Spec rule: slot k carries bit W-1-tz(k+1); last slot is 0.
  function automatic logic exp_bit(input logic [W-1:0] x, input int k);
    int v, t;
    if (k == L - 1) return 1'b0;
    v = k + 1;
    t = 0;
    while (v % 2 == 0) begin
      v = v / 2;
      t++;
    end
    return x[W-1-t];
  endfunction

  function automatic logic [OW-1:0] obs();
    logic [CH-1:0] b;
    b = bus.o_sn_bits;
`ifdef SNG_LFSR_EN
    b = '0;
`endif
    return {bus.o_sn_valid, bus.o_sn_last, bus.o_done,
            bus.o_aborted, bus.o_busy, b};
  endfunction

  task automatic run(input logic [XW-1:0] xv, input int stop_at,
                     input bit hold, input int chg_at, input int rst_at);
    int k;
    bit ended;
    int cnt [CH];
    logic [CH-1:0] eb;
    logic [OW-1:0] ev;
    for (int c = 0; c < CH; c++) cnt[c] = 0;
    s0 = '0;
    @(posedge clk); #1;
    bus.i_start_sng = 1'b1;
    bus.i_stop_sng  = 1'b1;
    bus.i_x_bn      = xv;
    @(negedge clk);
    check("idle", obs(), '0);
    k = 0;
    ended = 1'b0;
    while (!ended) begin
      @(posedge clk); #1;
      bus.i_start_sng = hold;
      bus.i_stop_sng  = (k == stop_at);
      if (k == chg_at) bus.i_x_bn = XW'($urandom);
      @(negedge clk);
      for (int c = 0; c < CH; c++) eb[c] = exp_bit(xv[c*W +: W], k);
`ifdef SNG_LFSR_EN
      ev = {1'b1, (k == L - 1), 3'b001, {CH{1'b0}}};
`else
      ev = {1'b1, (k == L - 1), 3'b001, eb};
`endif
      check($sformatf("gen_k%0d", k), obs(), ev);
      for (int c = 0; c < CH; c++) cnt[c] += int'(bus.o_sn_bits[c]);
      s0 = {s0[L-2:0], bus.o_sn_bits[0]};
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1 check("async_rst", {obs(), bus.o_sn_bits}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_start_sng = 1'b0;
        bus.i_stop_sng  = 1'b0;
        return;
      end
      if (k == L - 1 || k == stop_at) ended = 1'b1;
      k++;
    end
    @(posedge clk); #1;
    bus.i_start_sng = 1'b0;
    bus.i_stop_sng  = 1'b1;
    @(negedge clk);
    ev = {3'b001, (stop_at >= 0 && stop_at < L - 1), 1'b1,
          {CH{1'b0}}};
    check("done", {obs(), bus.o_sn_bits}, {ev, {CH{1'b0}}});
    if (!(stop_at >= 0 && stop_at < L - 1)) begin
      for (int c = 0; c < CH; c++)
        check($sformatf("ones_c%0d", c), cnt[c], xv[c*W +: W]);
    end
  endtask

  initial begin
    logic [XW-1:0] xv;
    int sa;
    bus.i_start_sng = 1'b0;
    bus.i_stop_sng  = 1'b0;
    bus.i_x_bn      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {obs(), bus.o_sn_bits}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef SNG_LFSR_EN
    run({5'd31, 5'd17}, -1, 1'b0, -1, -1);
    run({5'd31, 5'd0}, -1, 1'b1, 4, -1);
`else
    run({4'd15, 4'd8, 4'd1, 4'd0}, -1, 1'b0, -1, -1);
    run({4'd0, 4'd0, 4'd0, 4'b1010}, -1, 1'b0, -1, -1);
    check("pat_1010", s0, 16'hBABA);
    run({4'd3, 4'd12, 4'd7, 4'd9}, 5, 1'b0, -1, -1);
    run({4'd3, 4'd12, 4'd7, 4'd9}, -1, 1'b0, -1, -1);
    run({4'd6, 4'd5, 4'd14, 4'd11}, 6, 1'b1, 3, -1);
`endif
    run(XW'($urandom), L - 1, 1'b0, -1, -1);
    run(XW'($urandom), -1, 1'b0, -1, 7);
    run({CH{W'(L - 1)}}, -1, 1'b0, -1, -1);
    for (int i = 0; i < 10; i++) begin
      xv = XW'($urandom);
      sa = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, L - 1);
      run(xv, sa, 1'($urandom_range(0, 1)),
          $urandom_range(0, L - 1), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
